spi_slave: RTL and testbench

- SPI slave front end that feeds the single-port RAM command interface.
- Deserialises 10-bit MOSI frames (2-bit command plus 8-bit payload) into rx_data and pulses rx_valid.
- For read-data frames, waits for the RAM's tx_valid/tx_data and serialises the byte back on MISO.
- Sits between the chip-level SPI pins and the RAM; the SPI serial clock is the system clk.

---
 rtl/spi_slave.sv | 151 +++++++++++++++
 tb/tb_spi_slave.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave front end for the single-port RAM: deserialises 10-bit command
// frames onto rx_data/rx_valid and serialises RAM read bytes back on MISO.
module spi_slave #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid
);

   localparam int FRAME_W  = DATA_W + 2;
   localparam int CNT_W    = $clog2(FRAME_W);
   localparam int TX_CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]    PAYLOAD_BITS = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0]    LAST_SHIFT   = CNT_W'(FRAME_W - 2);
   localparam logic [TX_CNT_W-1:0] TX_REMAIN    = TX_CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [CNT_W-1:0]    bit_cnt;
   logic [DATA_W-2:0]   tx_shift;
   logic [TX_CNT_W-1:0] tx_left;
   logic                tx_pending;
   logic                rd_addr_done;
   logic                abort;
   logic                cmd_load;
   logic                shift_en;
   logic                frame_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The counter saturates at the payload length, so bits after a complete frame are ignored.
   always_comb begin
      next_state = state;
      abort      = 1'b0;
      cmd_load   = 1'b0;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (!SS_n) begin
               next_state = CHK_CMD;
            end
         end
         CHK_CMD: begin
            if (SS_n) begin
               abort      = 1'b1;
               next_state = IDLE;
            end else begin
               cmd_load = 1'b1;
               if (!MOSI) begin
                  next_state = WRITE;
               end else if (rd_addr_done) begin
                  next_state = READ_DATA;
               end else begin
                  next_state = READ_ADD;
               end
            end
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (SS_n) begin
               abort      = 1'b1;
               next_state = IDLE;
            end else if (bit_cnt < PAYLOAD_BITS) begin
               shift_en   = 1'b1;
               frame_done = (bit_cnt == LAST_SHIFT);
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         bit_cnt      <= '0;
         rd_addr_done <= 1'b0;
      end else begin
         rx_valid <= frame_done;
         if (state == IDLE) begin
            bit_cnt <= '0;
         end
         if (cmd_load) begin
            rx_data[FRAME_W-1] <= MOSI;
         end
         if (shift_en) begin
            rx_data[FRAME_W-2:0] <= {rx_data[FRAME_W-3:0], MOSI};
            bit_cnt              <= bit_cnt + CNT_W'(1);
         end
         if (frame_done && state == READ_ADD) begin
            rd_addr_done <= 1'b1;
         end else if (frame_done && state == READ_DATA) begin
            rd_addr_done <= 1'b0;
         end
      end
   end

   // tx_pending is set only at frame completion, so a tx_valid already high at that edge is not taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         MISO       <= 1'b0;
         tx_shift   <= '0;
         tx_left    <= '0;
         tx_pending <= 1'b0;
      end else begin
         if (abort) begin
            MISO       <= 1'b0;
            tx_left    <= '0;
            tx_pending <= 1'b0;
         end else if (tx_pending && tx_valid) begin
            MISO       <= tx_data[DATA_W-1];
            tx_shift   <= tx_data[DATA_W-2:0];
            tx_left    <= TX_REMAIN;
            tx_pending <= 1'b0;
         end else if (tx_left != '0) begin
            MISO     <= tx_shift[DATA_W-2];
            tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
            tx_left  <= tx_left - TX_CNT_W'(1);
         end else begin
            MISO <= 1'b0;
         end
         if (frame_done && state == READ_DATA) begin
            tx_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: frames are driven bit by bit, expected frames and
// MISO bits go into scoreboard queues, and a small RAM model answers read-data frames.
module tb_spi_slave;

   logic       clk;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int         checks;
   int         failures;
   logic [9:0] exp_q[$];
   logic       miso_q[$];
   logic       model_rd_done;
   logic [7:0] ram_byte;
   logic       ram_launch;

   spi_slave #(.DATA_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are compared 1 ns later, and the RAM model reacts to rx_valid.
   task automatic tick();
      logic [9:0] exp_frame;
      logic       exp_miso;
      @(posedge clk);
      #1;
      exp_miso = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b0;
      checkOutput("miso", MISO, exp_miso);
      if (ram_launch) begin
         tx_valid   = 1'b1;
         tx_data    = ram_byte;
         ram_launch = 1'b0;
      end
      if (rx_valid) begin
         tx_valid = 1'b0;
         if (exp_q.size() > 0) begin
            exp_frame = exp_q.pop_front();
            checkOutput("rx_data", rx_data, exp_frame);
            ram_launch = (exp_frame[9:8] == 2'b11);
         end else begin
            checkOutput("rx_unexpected", rx_valid, 1'b0);
         end
      end
   endtask

   // Sends nbits of a frame (10 = complete), then extra ignored bits, then raises SS_n.
   task automatic applyStimulus(input logic [9:0] frame, input int nbits, input int extra);
      logic is_rd_data;
      is_rd_data = frame[9] && model_rd_done;
      if (nbits == 10) exp_q.push_back(frame);
      SS_n = 1'b0;
      MOSI = 1'b0;
      tick();
      for (int i = 0; i < nbits; i++) begin
         MOSI = frame[9-i];
         tick();
         checkOutput("rx_valid_timing", rx_valid, (nbits == 10 && i == 9));
      end
      if (nbits == 10) begin
         if (frame[9]) model_rd_done = !is_rd_data;
         if (is_rd_data) begin
            miso_q.push_back(1'b0);
            for (int b = 7; b >= 0; b--) miso_q.push_back(ram_byte[b]);
         end
      end
      for (int i = 0; i < extra; i++) begin
         MOSI = 1'($urandom_range(0, 1));
         tick();
         checkOutput("rx_valid_extra", rx_valid, 1'b0);
      end
      miso_q.delete();
      SS_n = 1'b1;
      MOSI = 1'b0;
      tick();
      checkOutput("rx_drained", exp_q.size(), 0);
      checkOutput("rd_addr_done", dut.rd_addr_done, model_rd_done);
      tick();
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      model_rd_done = 1'b0;
      ram_byte      = 8'hC3;
      ram_launch    = 1'b0;
      rst_n         = 1'b0;
      SS_n          = 1'b0;
      MOSI          = 1'b0;
      tx_data       = 8'h00;
      tx_valid      = 1'b0;

      $display("[TB] reset with SS_n low and MOSI toggling");
      for (int i = 0; i < 12; i++) begin
         MOSI = i[0];
         tick();
         checkOutput("rst_rx_valid", rx_valid, 1'b0);
      end
      checkOutput("rst_rx_data", rx_data, 10'h000);
      checkOutput("rst_rd_addr_done", dut.rd_addr_done, 1'b0);
      rst_n = 1'b1;
      SS_n  = 1'b1;
      tick();
      tick();

      $display("[TB] write-address and write-data frames");
      applyStimulus(10'h0A5, 10, 3);
      applyStimulus(10'h13C, 10, 2);

      $display("[TB] read-address then read-data returning 0xC3");
      applyStimulus(10'h207, 10, 0);
      ram_byte = 8'hC3;
      applyStimulus(10'h3E1, 10, 10);

      $display("[TB] aborted read-address frame then a clean frame");
      applyStimulus(10'h2FF, 5, 0);
      applyStimulus(10'h055, 10, 1);

      $display("[TB] read-data command without address routes to read-address");
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      applyStimulus(10'h35A, 10, 10);

      $display("[TB] stale tx_valid held high before a read-data frame");
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      ram_byte = 8'hA6;
      applyStimulus(10'h300, 10, 12);

      $display("[TB] transmit aborted by SS_n, then a write frame with tx_valid high");
      applyStimulus(10'h2AA, 10, 0);
      ram_byte = 8'h81;
      applyStimulus(10'h3FF, 10, 3);
      applyStimulus(10'h0FF, 10, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
